// File: rtl/bus_arb_ctrl.sv
// -----------------------------------------------------------------------------
// bus_arb_ctrl
//   DMA bus-mastership arbiter for a 68030 bus. It requests the bus on behalf
//   of CPU_SM, waits for the grant and for the bus to go quiet, holds the bus
//   until the current DMA cycle completes, and then releases it and backs off
//   for a fixed number of cycles before it requests again.
//
// Parameters
//   GRANT_TIMEOUT   max REQ-state cycles spent waiting for the bus grant
//   HOLD_LIMIT      OWN-state cycles after which the bus is given up at the
//                   next completed cycle
//   BACKOFF_CYCLES  idle cycles between a release and the next request
//                   (0 behaves as 1)
//
// Ports (the signal names of the bus are shown in brackets)
//   clk45_i         sole clock, rising edge                      [CLK45]
//   reset_i         synchronous active-high reset                [RESET]
//   dma_req_i       CPU_SM wants bus mastership                  [DMA_REQ]
//   cycledone_i     no DMA bus cycle in progress                 [CYCLEDONE]
//   bg_n_i          bus grant, active low                        [BG_]
//   as_in_n_i       sensed address strobe, active low            [AS_IN_]
//   dsack0_n_i      sensed DSACK0, active low                    [DSACK0_]
//   dsack1_n_i      sensed DSACK1, active low                    [DSACK1_]
//   bgack_in_n_i    sensed BGACK from other masters, active low  [BGACK_IN_]
//   br_n_o          bus request to the CPU, active low           [BR_]
//   bgack_n_o       our bus-grant acknowledge, active low        [BGACK_]
//   bgrant_n_o      mastership indication to CPU_SM, active low  [BGRANT_]
//   arb_timeout_o   one-cycle pulse when a grant wait expires    [ARB_TIMEOUT]
//   arb_state_o     current state encoding, for debug            [ARB_STATE]
//
// All inputs arrive already synchronised to clk45_i and are used as sampled.
// -----------------------------------------------------------------------------
module bus_arb_ctrl #(
    parameter logic [7:0] GRANT_TIMEOUT  = 8'd200,
    parameter logic [7:0] HOLD_LIMIT     = 8'd64,
    parameter logic [2:0] BACKOFF_CYCLES = 3'd4
) (
    input  logic       clk45_i,
    input  logic       reset_i,
    input  logic       dma_req_i,
    input  logic       cycledone_i,
    input  logic       bg_n_i,
    input  logic       as_in_n_i,
    input  logic       dsack0_n_i,
    input  logic       dsack1_n_i,
    input  logic       bgack_in_n_i,
    output logic       br_n_o,
    output logic       bgack_n_o,
    output logic       bgrant_n_o,
    output logic       arb_timeout_o,
    output logic [2:0] arb_state_o
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BO_W    = 3;

    // State encodings, visible on arb_state_o
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQ      = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_BUS = 3'd2;
    localparam logic [STATE_W-1:0] ST_OWN      = 3'd3;
    localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_BACKOFF  = 3'd5;

    // Last backoff count value before returning to IDLE; 0 cycles acts as 1
    localparam logic [BO_W-1:0] BO_LAST =
        (BACKOFF_CYCLES == 3'd0) ? 3'd0 : BACKOFF_CYCLES - 3'd1;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    logic [STATE_W-1:0] state_q,    state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [BO_W-1:0]    bo_cnt_q,   bo_cnt_d;
    logic               br_n_q,     br_n_d;
    logic               bgack_n_q,  bgack_n_d;
    logic               bgrant_n_q, bgrant_n_d;
    logic               timeout_q,  timeout_d;

    // Bus is quiet: no strobe, no acknowledges, no other master holding BGACK
    logic bus_free_c;
    assign bus_free_c = as_in_n_i & dsack0_n_i & dsack1_n_i & bgack_in_n_i;

    // State, counters and registered outputs
    always_ff @(posedge clk45_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            hold_cnt_q <= '0;
            bo_cnt_q   <= '0;
            br_n_q     <= 1'b1;
            bgack_n_q  <= 1'b1;
            bgrant_n_q <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            bo_cnt_q   <= bo_cnt_d;
            br_n_q     <= br_n_d;
            bgack_n_q  <= bgack_n_d;
            bgrant_n_q <= bgrant_n_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        timeout_d  = 1'b0;
        wait_cnt_d = '0;
        hold_cnt_d = '0;
        bo_cnt_d   = '0;
        br_n_d     = 1'b1;
        bgack_n_d  = 1'b1;
        bgrant_n_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (dma_req_i) begin
                    state_d = ST_REQ;
                end
            end

            // Grant is checked first so it wins over a coincident timeout
            ST_REQ: begin
                if (!bg_n_i) begin
                    state_d = ST_WAIT_BUS;
                end else if (!dma_req_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == GRANT_TIMEOUT) begin
                    state_d   = ST_BACKOFF;
                    timeout_d = 1'b1;
                end
            end

            // Granted; wait for the current bus owner to finish
            ST_WAIT_BUS: begin
                if (!dma_req_i) begin
                    state_d = ST_IDLE;
                end else if (bg_n_i) begin
                    state_d = ST_REQ;
                end else if (bus_free_c) begin
                    state_d = ST_OWN;
                end
            end

            // Only leave between DMA cycles; BG_ is irrelevant once we own it
            ST_OWN: begin
                if (cycledone_i && (!dma_req_i || (hold_cnt_q >= HOLD_LIMIT))) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_d = ST_BACKOFF;
            end

            ST_BACKOFF: begin
                if (bo_cnt_q == BO_LAST) begin
                    state_d = ST_IDLE;
                end
            end

            // Unused encodings recover to IDLE
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Each counter runs only while its state is held and restarts at 0 on entry
        if ((state_q == ST_REQ) && (state_d == ST_REQ)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if ((state_q == ST_OWN) && (state_d == ST_OWN)) begin
            hold_cnt_d = (hold_cnt_q == CNT_MAX) ? CNT_MAX : hold_cnt_q + 8'd1;
        end

        if ((state_q == ST_BACKOFF) && (state_d == ST_BACKOFF)) begin
            bo_cnt_d = bo_cnt_q + 3'd1;
        end

        // Outputs decoded from the next state so they line up with the state register
        br_n_d     = !((state_d == ST_REQ) || (state_d == ST_WAIT_BUS));
        bgack_n_d  = (state_d != ST_OWN);
        bgrant_n_d = (state_d != ST_OWN);
    end

    assign br_n_o        = br_n_q;
    assign bgack_n_o     = bgack_n_q;
    assign bgrant_n_o    = bgrant_n_q;
    assign arb_timeout_o = timeout_q;
    assign arb_state_o   = state_q;

endmodule

// File: tb/tb_bus_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_arb_ctrl
//   Two arbiters share one set of inputs: one with the default parameters and
//   one with a short grant timeout, short hold limit and BACKOFF_CYCLES=0.
//   A phase/age reference model predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_bus_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, dma_req, cycledone, bg_n, as_in_n, dsack0_n, dsack1_n, bgack_in_n;

    logic [1:0] br_n, bgack_n, bgrant_n, arb_timeout;
    logic [2:0] arb_state0, arb_state1;

    bus_arb_ctrl u_dut0 (
        .clk45_i      (clk),
        .reset_i      (reset),
        .dma_req_i    (dma_req),
        .cycledone_i  (cycledone),
        .bg_n_i       (bg_n),
        .as_in_n_i    (as_in_n),
        .dsack0_n_i   (dsack0_n),
        .dsack1_n_i   (dsack1_n),
        .bgack_in_n_i (bgack_in_n),
        .br_n_o       (br_n[0]),
        .bgack_n_o    (bgack_n[0]),
        .bgrant_n_o   (bgrant_n[0]),
        .arb_timeout_o(arb_timeout[0]),
        .arb_state_o  (arb_state0)
    );

    bus_arb_ctrl #(
        .GRANT_TIMEOUT (8'd5),
        .HOLD_LIMIT    (8'd3),
        .BACKOFF_CYCLES(3'd0)
    ) u_dut1 (
        .clk45_i      (clk),
        .reset_i      (reset),
        .dma_req_i    (dma_req),
        .cycledone_i  (cycledone),
        .bg_n_i       (bg_n),
        .as_in_n_i    (as_in_n),
        .dsack0_n_i   (dsack0_n),
        .dsack1_n_i   (dsack1_n),
        .bgack_in_n_i (bgack_in_n),
        .br_n_o       (br_n[1]),
        .bgack_n_o    (bgack_n[1]),
        .bgrant_n_o   (bgrant_n[1]),
        .arb_timeout_o(arb_timeout[1]),
        .arb_state_o  (arb_state1)
    );

    // Reference model: phase 0..5 (IDLE,REQ,WAIT_BUS,OWN,RELEASE,BACKOFF),
    // age = cycles already spent in the current phase
    int ph    [2];
    int age   [2];
    bit to_p  [2];
    int gt    [2] = '{200, 5};
    int hl    [2] = '{64, 3};
    int bc    [2] = '{4, 0};

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int i);
        int  nph;
        int  held;
        int  bo_len;
        bit  bus_free;
        nph      = ph[i];
        to_p[i]  = 1'b0;
        bus_free = as_in_n && dsack0_n && dsack1_n && bgack_in_n;
        held     = (age[i] > 255) ? 255 : age[i];
        bo_len   = (bc[i] == 0) ? 1 : bc[i];
        if (reset) begin
            ph[i]  = 0;
            age[i] = 0;
            return;
        end
        case (ph[i])
            0: if (dma_req) nph = 1;
            1: begin
                if (!bg_n)                nph = 2;
                else if (!dma_req)        nph = 0;
                else if (age[i] == gt[i]) begin nph = 5; to_p[i] = 1'b1; end
            end
            2: begin
                if (!dma_req)      nph = 0;
                else if (bg_n)     nph = 1;
                else if (bus_free) nph = 3;
            end
            3: if (cycledone && (!dma_req || held >= hl[i])) nph = 4;
            4: nph = 5;
            5: if (age[i] + 1 >= bo_len) nph = 0;
            default: nph = 0;
        endcase
        if (nph != ph[i]) age[i] = 0;
        else              age[i] = age[i] + 1;
        ph[i] = nph;
    endtask

    task automatic check_all();
        logic [2:0] st;
        for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? arb_state0 : arb_state1;
            check($sformatf("u%0d.state", i), 8'(st), 8'(ph[i]));
            check($sformatf("u%0d.br_n", i), 8'(br_n[i]),
                  8'((ph[i] == 1 || ph[i] == 2) ? 0 : 1));
            check($sformatf("u%0d.bgack_n", i), 8'(bgack_n[i]), 8'((ph[i] == 3) ? 0 : 1));
            check($sformatf("u%0d.bgrant_n", i), 8'(bgrant_n[i]), 8'((ph[i] == 3) ? 0 : 1));
            check($sformatf("u%0d.timeout", i), 8'(arb_timeout[i]), 8'(to_p[i]));
            check($sformatf("u%0d.br_bgack_excl", i), 8'(br_n[i] | bgack_n[i]), 8'd1);
        end
    endtask

    // Drive inputs, clock once, advance the model and compare after the edge
    task automatic step(input bit rst, input bit dma, input bit cd, input bit bg,
                        input bit as_i, input bit d0, input bit d1, input bit bgin);
        reset = rst; dma_req = dma; cycledone = cd; bg_n = bg;
        as_in_n = as_i; dsack0_n = d0; dsack1_n = d1; bgack_in_n = bgin;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_all();
    endtask

    int pulses;
    int k;

    initial begin
        reset = 1'b1; dma_req = 1'b0; cycledone = 1'b0; bg_n = 1'b1;
        as_in_n = 1'b1; dsack0_n = 1'b1; dsack1_n = 1'b1; bgack_in_n = 1'b1;
        ph = '{0, 0}; age = '{0, 0}; to_p = '{0, 0};

        // Reset state
        step(1, 0, 0, 1, 1, 1, 1, 1);
        step(1, 0, 0, 1, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1, 1, 1);

        // Basic grant: request, BG_ low three cycles later, bus idle
        step(0, 1, 0, 1, 1, 1, 1, 1);
        check("basic.br_low", 8'(br_n[0]), 8'd0);
        step(0, 1, 0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 1, 1, 1);
        check("basic.bgack_low", 8'(bgack_n[0]), 8'd0);
        // Drop request but keep the cycle running: must stay in OWN
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 1, 1);
        check("own.hold_no_cd", 8'(arb_state0), 8'd3);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, 1, 1, 1);

        // Timeout: BG_ held high with request asserted
        pulses = 0;
        for (int i = 0; i < 215; i++) begin
            step(0, 1, 0, 1, 1, 1, 1, 1);
            if (arb_timeout[0]) pulses++;
        end
        check("timeout.pulse_count", 8'(pulses), 8'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1, 1, 1);

        // Busy bus: granted while AS_ low for five cycles, then bus frees
        step(0, 1, 0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 1, 1, 1);
        check("busy.wait_bus", 8'(arb_state0), 8'd2);
        step(0, 1, 0, 0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1, 1, 0);
        step(0, 1, 0, 0, 1, 1, 1, 1);
        check("busy.own", 8'(arb_state0), 8'd3);

        // Hold limit: CYCLEDONE low until cycle 70, then one completed cycle
        for (int i = 0; i < 70; i++) step(0, 1, 0, 0, 1, 1, 1, 1);
        check("hold.still_own", 8'(arb_state0), 8'd3);
        step(0, 1, 1, 0, 1, 1, 1, 1);
        check("hold.release", 8'(arb_state0), 8'd4);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 1, 1, 1);

        // Reset in OWN
        k = 0;
        while (!(ph[0] == 3) && k < 50) begin
            step(0, 1, 0, 0, 1, 1, 1, 1);
            k++;
        end
        check("rst_own.reached", 8'(bgack_n[0]), 8'd0);
        step(1, 1, 0, 0, 1, 1, 1, 1);
        check("rst_own.state", 8'(arb_state0), 8'd0);
        check("rst_own.bgack", 8'(bgack_n[0]), 8'd1);
        step(0, 0, 0, 0, 1, 1, 1, 1);

        // Race: BG_ falls exactly when the wait counter equals GRANT_TIMEOUT
        k = 0;
        while (!(ph[0] == 1 && age[0] == 200) && k < 400) begin
            step(0, 1, 0, 1, 1, 1, 1, 1);
            k++;
        end
        check("race.setup_req", 8'(arb_state0), 8'd1);
        step(0, 1, 0, 0, 0, 1, 1, 1);
        check("race.wait_bus", 8'(arb_state0), 8'd2);
        check("race.no_timeout", 8'(arb_timeout[0]), 8'd0);

        // Same race on the short-timeout instance
        step(1, 0, 0, 1, 1, 1, 1, 1);
        k = 0;
        while (!(ph[1] == 1 && age[1] == 5) && k < 50) begin
            step(0, 1, 0, 1, 1, 1, 1, 1);
            k++;
        end
        check("race1.setup_req", 8'(arb_state1), 8'd1);
        step(0, 1, 0, 0, 0, 1, 1, 1);
        check("race1.wait_bus", 8'(arb_state1), 8'd2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 1,
                 $urandom_range(99) < 85,
                 $urandom_range(99) < 40,
                 $urandom_range(99) < 45,
                 $urandom_range(99) < 80,
                 $urandom_range(99) < 90,
                 $urandom_range(99) < 90,
                 $urandom_range(99) < 90);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
